inst_fetch_arbiter: RTL
=======================

INST_FETCH_ARBITER -- requirements
Module: inst_fetch_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the byte-address width of all address ports.
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction word width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-005 if_req  in  1  SHALL be the fetch-stage request, held high with if_addr stable until if_ack.
REQ-006 if_addr  in  ADDR_W  SHALL be the fetch-stage byte address.
REQ-007 if_ack  out  1  SHALL be a one-cycle pulse completing a fetch-stage request.
REQ-008 if_inst  out  DATA_W  SHALL be the fetch-stage returned word, valid while if_ack=1.
REQ-009 if_stall  out  1  SHALL equal if_req & ~if_ack (combinational).
REQ-010 dbg_req  in  1  SHALL be the debug/loader read request, same holding rule as if_req.
REQ-011 dbg_addr  in  ADDR_W  SHALL be the debug byte address.
REQ-012 dbg_ack  out  1  SHALL be a one-cycle pulse completing a debug request.
REQ-013 dbg_inst  out  DATA_W  SHALL be the debug returned word, valid while dbg_ack=1.
REQ-014 err  out  1  SHALL flag, alongside the ack, that the completed request was misaligned.
REQ-015 rom_ce  out  1  SHALL be the ROM chip enable (1 = enabled), driven combinationally from state.
REQ-016 rom_addr  out  ADDR_W  SHALL be the ROM byte address, combinational from the latched request.
REQ-017 rom_inst  in  DATA_W  SHALL be the ROM's combinational read data.

Function
REQ-018 FSM states SHALL be IDLE and ACCESS.
REQ-019 IDLE: if any eligible request, SHALL latch winner id and address, go to ACCESS; else stay IDLE.
REQ-020 ACCESS: rom_ce=1, rom_addr=latched address; on the clock edge, SHALL register rom_inst into the winner's data output, pulse the winner's ack next cycle, return to IDLE.
REQ-021 Latency SHALL be exactly 2 cycles from grant in IDLE to ack (grant cycle N, ACCESS N+1, ack N+2).
REQ-022 The ack cycle is an IDLE cycle; a new grant SHALL be possible in that same cycle, giving one completion per 2 cycles sustained.
REQ-023 A requester SHALL NOT be eligible in the cycle its own ack is high (its req is stale that cycle).
REQ-024 Arbitration SHALL be round-robin: a 1-bit last-winner register gives priority to the other port when both are eligible; reset priority favours IF.
REQ-025 Only one ack SHALL be high in any cycle; the non-acked port's data output SHALL hold its previous value.
REQ-026 If the latched address has bits[1:0] != 0, ACCESS SHALL keep rom_ce=0, return data 0, and assert err with the ack.
REQ-027 rom_ce SHALL be 0 and rom_addr 0 in IDLE.
REQ-028 A requester dropping req before its ack (protocol violation) SHALL NOT abort the transaction; the ack still issues.
REQ-029 Request inputs SHALL be sampled only in IDLE; changes during ACCESS SHALL be ignored.

Reset
REQ-030 While rst=0: state=IDLE, all acks=0, err=0, if_inst=0, dbg_inst=0, rom_ce=0, rom_addr=0, last-winner=DBG (so IF wins first).
REQ-031 Reset asserted mid-ACCESS SHALL abandon the transaction with no ack after release.
REQ-032 First grant SHALL be possible in the first clock edge after rst returns to 1.

Verification
REQ-033 IF-only: if_req=1, if_addr=0x0000_0008, rom word 0x3401_0020 -> rom_ce=1 with rom_addr=0x08 in cycle N+1, if_ack=1 and if_inst=0x3401_0020 in N+2, if_stall=1 in N..N+1.
REQ-034 Contention: both req held from reset release -> acks alternate IF, DBG, IF, DBG, each 2 cycles apart, never simultaneous.
REQ-035 Misaligned: dbg_addr=0x0000_0006 -> rom_ce stays 0, dbg_ack=1, err=1, dbg_inst=0.
REQ-036 Back-to-back: IF acked at cycle N, dbg_req rising at N -> DBG granted at N, dbg_ack at N+2; IF not regranted at N.
REQ-037 Reset mid-op: rst=0 during ACCESS -> rom_ce=0 immediately, no ack after rst=1, next request completes normally with IF priority.
REQ-038 Idle: no requests for 10 cycles -> rom_ce=0, rom_addr=0, acks=0 throughout.

Source files
------------

// File: rtl/inst_fetch_arbiter.sv
// Two-port instruction fetch arbiter (fetch stage and debug/loader) sharing one
// combinational-read ROM; round-robin grant, two-cycle latency, misalignment flagged.
module inst_fetch_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_stall,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_inst,
    output logic              err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic              r_win;
    logic [ADDR_W-1:0] r_addr;
    logic              r_if_ack;
    logic              r_dbg_ack;
    logic              r_err;
    logic [DATA_W-1:0] r_if_inst;
    logic [DATA_W-1:0] r_dbg_inst;

    logic              w_if_elig;
    logic              w_dbg_elig;
    logic              w_grant;
    logic              w_pick;
    logic              w_misal;

    // A port's request is stale during its own ack cycle, so it cannot re-win then.
    assign w_if_elig  = if_req  & ~r_if_ack;
    assign w_dbg_elig = dbg_req & ~r_dbg_ack;
    assign w_grant    = (r_state == S_IDLE) & (w_if_elig | w_dbg_elig);
    assign w_misal    = (r_addr[1:0] != 2'b00);

    // 0 = IF, 1 = DBG; on contention the port that did not win last time goes.
    always_comb begin
        w_pick = 1'b0;
        if (w_if_elig && w_dbg_elig) begin
            w_pick = ~r_last;
        end else if (w_dbg_elig) begin
            w_pick = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_grant) w_next = S_ACCESS;
            S_ACCESS: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rom_ce   = 1'b0;
        rom_addr = '0;
        if (r_state == S_ACCESS) begin
            rom_ce   = ~w_misal;
            rom_addr = r_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last     <= 1'b1;
            r_win      <= 1'b0;
            r_addr     <= '0;
            r_if_ack   <= 1'b0;
            r_dbg_ack  <= 1'b0;
            r_err      <= 1'b0;
            r_if_inst  <= '0;
            r_dbg_inst <= '0;
        end else begin
            r_if_ack  <= 1'b0;
            r_dbg_ack <= 1'b0;
            r_err     <= 1'b0;
            if (w_grant) begin
                r_win  <= w_pick;
                r_last <= w_pick;
                r_addr <= w_pick ? dbg_addr : if_addr;
            end
            if (r_state == S_ACCESS) begin
                r_err <= w_misal;
                if (r_win) begin
                    r_dbg_ack  <= 1'b1;
                    r_dbg_inst <= w_misal ? '0 : rom_inst;
                end else begin
                    r_if_ack  <= 1'b1;
                    r_if_inst <= w_misal ? '0 : rom_inst;
                end
            end
        end
    end

    assign if_ack   = r_if_ack;
    assign dbg_ack  = r_dbg_ack;
    assign err      = r_err;
    assign if_inst  = r_if_inst;
    assign dbg_inst = r_dbg_inst;
    assign if_stall = if_req & ~r_if_ack;

endmodule
